// File: rtl/mdu_seq_pkg.sv
// Shared constants for the multiply sequencer: ULA op codes, R-type funct codes
// and the FSM state encoding.
package mdu_seq_pkg;

    localparam logic [3:0] OP_ADD      = 4'b0000;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic logic funct_is_mul(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU);
    endfunction

endpackage

// File: rtl/mdu_seq_neg.sv
// Conditional two's-complement negate; passes the input through when en is low.
module mdu_neg #(
    parameter int W = 64
) (
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    // Negate as invert-plus-one when enabled.
    always_comb begin
        if (en) begin
            dout = ~din + {{(W-1){1'b0}}, 1'b1};
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Radix-2 shift-add multiply sequencer for mult/multu; each partial-sum add is
// borrowed from the shared ULA through a request/grant handshake.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2:0]         state_r;
    logic [WIDTH-1:0]   op_a_r;
    logic [WIDTH-1:0]   op_b_r;
    logic               is_signed_r;
    logic               sign_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   mlo_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               accept_s;
    logic               in_iter_s;
    logic               carry_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [2*WIDTH-1:0] fix_s;

    assign accept_s  = start && funct_is_mul(funct) &&
                       ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign in_iter_s = (state_r == ST_ITER);
    // The ULA result wrapped below acc exactly when the add carried out.
    assign carry_s   = (alu_result < acc_r);

    mdu_neg #(.W(WIDTH)) u_mag_a (
        .en   (is_signed_r & op_a_r[WIDTH-1]),
        .din  (op_a_r),
        .dout (mag_a_s)
    );

    mdu_neg #(.W(WIDTH)) u_mag_b (
        .en   (is_signed_r & op_b_r[WIDTH-1]),
        .din  (op_b_r),
        .dout (mag_b_s)
    );

    mdu_neg #(.W(2*WIDTH)) u_fix (
        .en   (sign_r),
        .din  ({acc_r, mlo_r}),
        .dout (fix_s)
    );

    // ULA port and status outputs decoded from the state register.
    always_comb begin
        alu_req  = in_iter_s;
        alu_ctrl = OP_ADD;
        busy     = (state_r == ST_PREP) || (state_r == ST_ITER) || (state_r == ST_FIX);
        done     = (state_r == ST_DONE);
        hi       = hi_r;
        lo       = lo_r;
        if (in_iter_s) begin
            alu_a = acc_r;
            alu_b = mlo_r[0] ? mcand_r : {WIDTH{1'b0}};
        end else begin
            alu_a = {WIDTH{1'b0}};
            alu_b = {WIDTH{1'b0}};
        end
    end

    // Sequencer FSM, shift registers, iteration counter and HI/LO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            is_signed_r <= 1'b0;
            sign_r      <= 1'b0;
            mcand_r     <= {WIDTH{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            mlo_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        op_a_r      <= op_a;
                        op_b_r      <= op_b;
                        is_signed_r <= (funct == FUNCT_MULT);
                        state_r     <= ST_PREP;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    mcand_r <= mag_b_s;
                    mlo_r   <= mag_a_s;
                    sign_r  <= is_signed_r & (op_a_r[WIDTH-1] ^ op_b_r[WIDTH-1]);
                    acc_r   <= {WIDTH{1'b0}};
                    cnt_r   <= CW'(WIDTH);
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    if (alu_gnt) begin
                        acc_r <= {carry_s, alu_result[WIDTH-1:1]};
                        mlo_r <= {alu_result[0], mlo_r[WIDTH-1:1]};
                        cnt_r <= cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            state_r <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    acc_r   <= fix_s[2*WIDTH-1:WIDTH];
                    mlo_r   <= fix_s[WIDTH-1:0];
                    hi_r    <= fix_s[2*WIDTH-1:WIDTH];
                    lo_r    <= fix_s[WIDTH-1:0];
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: a simple adder stands in for the ULA and
// products are checked against 64-bit arithmetic.
module tb_mdu_seq;

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op_a, op_b;
    logic        alu_req, alu_gnt;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total  = 0;
    int passed = 0;

    mdu_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .funct      (funct),
        .op_a       (op_a),
        .op_b       (op_b),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    assign alu_result = alu_a + alu_b;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [5:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (f == F_MULT) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end else begin
            return {32'd0, a} * {32'd0, b};
        end
    endfunction

    // Runs one operation starting at a negedge; returns at the negedge of the done cycle.
    // gmode: 0 grant always, 1 deny on even-numbered ITER cycles, 2 random grant.
    task automatic do_mul(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int gmode, input bit noise,
                          output int cycles, output int reqs, output bit ctrl_bad,
                          output bit freeze_bad, output bit busy_bad, output bit hold_bad);
        logic [31:0] hi0, lo0, fa, fb;
        bit pend;
        int iter_n;
        hi0 = hi; lo0 = lo;
        cycles = 0; reqs = 0; iter_n = 0; pend = 1'b0; fa = 32'd0; fb = 32'd0;
        ctrl_bad = 1'b0; freeze_bad = 1'b0; busy_bad = 1'b0; hold_bad = 1'b0;
        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        for (int k = 1; k <= 200; k++) begin
            if (alu_ctrl !== 4'b0000) ctrl_bad = 1'b1;
            if (pend && (alu_a !== fa || alu_b !== fb)) freeze_bad = 1'b1;
            pend = 1'b0;
            if (done === 1'b1) begin
                cycles = k;
                if (busy !== 1'b0 || alu_req !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (hi !== hi0 || lo !== lo0) hold_bad = 1'b1;
            if (alu_req === 1'b1) begin
                reqs++;
                case (gmode)
                    0:       alu_gnt = 1'b1;
                    1:       alu_gnt = iter_n[0];
                    default: alu_gnt = ($urandom_range(0, 3) != 0);
                endcase
                iter_n++;
                if (!alu_gnt) begin
                    pend = 1'b1; fa = alu_a; fb = alu_b;
                end
            end else begin
                alu_gnt = 1'($urandom_range(0, 1));
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1)); funct = F_MULT;
                op_a = $urandom; op_b = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; alu_gnt = 1'b0; funct = 6'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (alu_req !== 1'b0) $display("FAIL reset_req: got %b want 0", alu_req); else passed++;
        total++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {hi, lo}); else passed++;
        total++; if ({alu_a, alu_b} !== 64'd0) $display("FAIL reset_alu_ops: got %h want 0", {alu_a, alu_b}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int cyc, rq; bit cb, fz, bb, hb;
        logic [63:0] exp_p;
        exp_p = ref_prod(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mul(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, cyc, rq, cb, fz, bb, hb);
        total++; if (cyc !== 35) $display("FAIL multu_max_latency: got %0d want 35", cyc); else passed++;
        total++; if ({hi, lo} !== exp_p) $display("FAIL multu_max_result: got %h want %h", {hi, lo}, exp_p); else passed++;
        total++; if (rq !== 32) $display("FAIL multu_max_req_cycles: got %0d want 32", rq); else passed++;
        total++; if (cb !== 1'b0) $display("FAIL multu_max_alu_ctrl: got bad=%b want 0", cb); else passed++;
        total++; if (bb !== 1'b0) $display("FAIL multu_max_busy: got bad=%b want 0", bb); else passed++;
    endtask

    task automatic test_mult_signed();
        int cyc, rq; bit cb, fz, bb, hb;
        logic [63:0] exp_p;
        exp_p = ref_prod(F_MULT, 32'hFFFF_FFFD, 32'd5);
        do_mul(F_MULT, 32'hFFFF_FFFD, 32'd5, 0, 1'b0, cyc, rq, cb, fz, bb, hb);
        total++; if ({hi, lo} !== exp_p) $display("FAIL mult_neg3x5: got %h want %h", {hi, lo}, exp_p); else passed++;
        exp_p = ref_prod(F_MULT, 32'h8000_0000, 32'h8000_0000);
        do_mul(F_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, cyc, rq, cb, fz, bb, hb);
        total++; if ({hi, lo} !== exp_p) $display("FAIL mult_minxmin: got %h want %h", {hi, lo}, exp_p); else passed++;
        exp_p = ref_prod(F_MULT, 32'd7, 32'hFFFF_FFF0);
        do_mul(F_MULT, 32'd7, 32'hFFFF_FFF0, 0, 1'b0, cyc, rq, cb, fz, bb, hb);
        total++; if ({hi, lo} !== exp_p) $display("FAIL mult_7xneg16: got %h want %h", {hi, lo}, exp_p); else passed++;
    endtask

    task automatic test_stall();
        int cyc, rq; bit cb, fz, bb, hb;
        do_mul(F_MULTU, 32'd7, 32'd6, 1, 1'b0, cyc, rq, cb, fz, bb, hb);
        total++; if (cyc !== 67) $display("FAIL stall_latency: got %0d want 67", cyc); else passed++;
        total++; if ({hi, lo} !== 64'd42) $display("FAIL stall_result: got %h want %h", {hi, lo}, 64'd42); else passed++;
        total++; if (fz !== 1'b0) $display("FAIL stall_freeze: got bad=%b want 0", fz); else passed++;
    endtask

    task automatic test_bad_funct();
        logic [31:0] hi0, lo0;
        bit moved;
        hi0 = hi; lo0 = lo; moved = 1'b0;
        start = 1'b1; funct = 6'h20; op_a = 32'd3; op_b = 32'd4;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || alu_req !== 1'b0 || done !== 1'b0) moved = 1'b1;
        end
        start = 1'b0;
        total++; if (moved !== 1'b0) $display("FAIL bad_funct_activity: got bad=%b want 0", moved); else passed++;
        total++; if ({hi, lo} !== {hi0, lo0}) $display("FAIL bad_funct_hilo: got %h want %h", {hi, lo}, {hi0, lo0}); else passed++;
    endtask

    task automatic test_busy_start();
        int cyc, rq; bit cb, fz, bb, hb;
        logic [63:0] exp_p;
        exp_p = ref_prod(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        do_mul(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1'b1, cyc, rq, cb, fz, bb, hb);
        total++; if ({hi, lo} !== exp_p) $display("FAIL busy_start_result: got %h want %h", {hi, lo}, exp_p); else passed++;
        total++; if (cyc !== 35) $display("FAIL busy_start_latency: got %0d want 35", cyc); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc, rq; bit cb, fz, bb, hb;
        do_mul(F_MULTU, 32'd2, 32'd3, 0, 1'b0, cyc, rq, cb, fz, bb, hb);
        total++; if ({hi, lo} !== 64'd6) $display("FAIL b2b_first: got %h want %h", {hi, lo}, 64'd6); else passed++;
        do_mul(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, cyc, rq, cb, fz, bb, hb);
        // Cycles strictly between the two done pulses.
        total++; if (cyc - 1 !== 34) $display("FAIL b2b_gap: got %0d want 34", cyc - 1); else passed++;
        total++; if (hb !== 1'b0) $display("FAIL b2b_hold: got bad=%b want 0", hb); else passed++;
        total++; if ({hi, lo} !== 64'd1) $display("FAIL b2b_second: got %h want %h", {hi, lo}, 64'd1); else passed++;
    endtask

    task automatic test_mid_reset();
        bit saw_done;
        saw_done = 1'b0;
        alu_gnt = 1'b1;
        start = 1'b1; funct = F_MULTU; op_a = $urandom; op_b = $urandom;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++; if (busy !== 1'b0 || alu_req !== 1'b0) $display("FAIL mid_reset_idle: got busy=%b req=%b want 0 0", busy, alu_req); else passed++;
        total++; if ({hi, lo} !== 64'd0) $display("FAIL mid_reset_hilo: got %h want 0", {hi, lo}); else passed++;
        repeat (60) begin
            if (done !== 1'b0) saw_done = 1'b1;
            @(negedge clk);
        end
        total++; if (saw_done !== 1'b0) $display("FAIL mid_reset_no_done: got %b want 0", saw_done); else passed++;
    endtask

    task automatic test_random();
        int cyc, rq; bit cb, fz, bb, hb;
        logic [5:0]  f;
        logic [31:0] a, b;
        logic [63:0] exp_p;
        for (int i = 0; i < 8; i++) begin
            f = ($urandom_range(0, 1) == 1) ? F_MULT : F_MULTU;
            a = $urandom; b = $urandom;
            exp_p = ref_prod(f, a, b);
            do_mul(f, a, b, 2, 1'b0, cyc, rq, cb, fz, bb, hb);
            total++; if ({hi, lo} !== exp_p) $display("FAIL rand_result[%0d] f=%h a=%h b=%h: got %h want %h", i, f, a, b, {hi, lo}, exp_p); else passed++;
            total++; if (cyc === 0 || cyc !== rq + 3) $display("FAIL rand_latency[%0d]: got %0d want %0d", i, cyc, rq + 3); else passed++;
            total++; if (fz !== 1'b0) $display("FAIL rand_freeze[%0d]: got bad=%b want 0", i, fz); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_stall();
        test_bad_funct();
        test_busy_start();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Multiply sequencer for the MIPS core's `mult`/`multu` instructions. It computes a WIDTH×WIDTH product by radix-2 shift-add over WIDTH iterations. Each partial-sum add is borrowed from the shared ULA through a request/grant port, and the 64-bit result is held in architectural HI/LO registers. The block sits beside the ULA in the execute stage; the datapath arbiter owns `alu_gnt`.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- start  in  1  request a multiply; sampled only in IDLE or DONE
- funct  in  6  R-type funct field; 6'h18 = mult (signed), 6'h19 = multu (unsigned)
- op_a, op_b  in  WIDTH  rs and rt values; sampled on the accepting edge
- alu_req  out  1  ULA needed this cycle
- alu_gnt  in  1  ULA granted this cycle
- alu_a, alu_b  out  WIDTH  ULA operands
- alu_ctrl  out  4  ULA operation; always 4'b0000 (ADD)
- alu_result  in  WIDTH  ULA result, combinational, same cycle
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi, lo  out  WIDTH  architectural HI/LO, read by mfhi/mflo

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- Start acceptance:
  - In IDLE or DONE, `start=1` with funct 6'h18 or 6'h19 latches op_a, op_b, funct and moves to PREP.
  - Any other funct is ignored and the state is unchanged.
- PREP:
  - For mult, the working multiplicand and multiplier become the magnitudes of op_b and op_a; the sign flag is op_a[MSB]^op_b[MSB].
  - 0x80000000 is treated as magnitude 0x80000000.
  - For multu, the operands are used as-is and the sign flag is 0.
  - Clear acc (WIDTH), set mlo = multiplier, load the iteration counter with WIDTH. Go to ITER.
- ITER:
  - `alu_req=1`, `alu_a=acc`, `alu_b = mlo[0] ? mcand : 0`.
  - On a cycle with `alu_gnt=1`:
    - carry = (alu_result < acc), unsigned compare done locally.
    - acc <= {carry, alu_result[WIDTH-1:1]}.
    - mlo <= {alu_result[0], mlo[WIDTH-1:1]}.
    - Decrement the counter; leave for FIX when it reaches 0.
  - `alu_gnt=0`: full stall. No register changes; alu_req and the operands stay stable.
- FIX: if the sign flag is set, {acc, mlo} <= two's-complement negation of {acc, mlo}, done locally without the ULA. Go to DONE.
- DONE: hi <= acc and lo <= mlo on entry; `done=1` for this one cycle. Next state is PREP if a valid start is present, else IDLE.
- Outputs:
  - `alu_req=0` outside ITER; alu_a/alu_b = 0 and alu_gnt is ignored outside ITER.
  - `busy=1` in PREP, ITER, FIX; 0 in IDLE and DONE.
- hi/lo change only on DONE entry and otherwise hold.

## Timing
- Reset (`rst_n=0` at an edge): state IDLE; hi, lo, acc, mlo, counter = 0; busy, done, alu_req = 0.
- Reset mid-operation aborts with no done pulse and clears hi/lo.
- Latency with `alu_gnt` held high:
  - start accepted at edge E0 → PREP in cycle 1, ITER in cycles 2..WIDTH+1, FIX in cycle WIDTH+2, DONE (done=1, hi/lo valid) in cycle WIDTH+3.
  - For WIDTH=32, done appears 35 cycles after the start edge.
- Each cycle of `alu_gnt=0` during ITER adds exactly one cycle of latency.
- Back-to-back: a start present in the DONE cycle begins the next operation with no idle cycle. hi/lo show the previous result until the new DONE.
- start while busy is ignored and not queued.

## Structure
- Shared package holds:
  - ULA op codes (OP_ADD = 4'b0000, shared with the ULA control decoder)
  - funct codes FUNCT_MULT = 6'h18 and FUNCT_MULTU = 6'h19
  - the state encoding
- One natural sub-module: `mdu_neg`, a combinational conditional two's-complement negate on 2·WIDTH bits used in FIX. The PREP magnitude logic reuses the same function at WIDTH bits.
- Everything else (FSM, counter, acc/mlo shift registers, HI/LO) stays in mdu_seq.

## Test plan
- multu, 0xFFFFFFFF × 0xFFFFFFFF, gnt=1 → done in cycle 35; hi=0xFFFFFFFE, lo=0x00000001. alu_req high exactly 32 cycles, alu_ctrl=0 throughout.
- mult, -3 × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. mult, 0x80000000 × 0x80000000 → hi=0x40000000, lo=0.
- multu, 7 × 6 with alu_gnt low on every other ITER cycle:
  - done at cycle 67 with hi=0, lo=42.
  - alu_a, alu_b and the counter are frozen on every stalled cycle.
- start with funct=6'h20 → busy, alu_req and done stay 0 and hi/lo are unchanged.
- Mid-run behaviour:
  - start pulses during busy are ignored.
  - rst_n low in cycle 10 → next cycle IDLE, hi=lo=0, and no done pulse ever appears.
- Back-to-back:
  - start in the DONE cycle (multu 2×3, then mult -1×-1) → results 6, then hi=0, lo=1.
  - Done pulses are 34 cycles apart.
  - hi/lo hold 6 until the second done.
